// File: rtl/scaled_bitmap_display.sv
// Scaled bitmap window renderer: maps raster position onto an external pixel-map ROM
// and converts colour indices to 12-bit RGB through a run-time writable palette.
module scaled_bitmap_display #(
   parameter int IMG_W      = 64,
   parameter int IMG_H      = 62,
   parameter int SCALE_LOG2 = 3,
   parameter int COLOR_BITS = 4,
   parameter int DEFAULT_X  = 0,
   parameter int DEFAULT_Y  = 0,
   parameter int ADDR_W     = $clog2(IMG_W*IMG_H)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [11:0]           hcount_in,
   input  logic [10:0]           vcount_in,
   input  logic                  frame_start_in,
   input  logic [11:0]           pos_x_in,
   input  logic [10:0]           pos_y_in,
   input  logic                  pos_we_in,
   input  logic                  pal_we_in,
   input  logic [COLOR_BITS-1:0] pal_addr_in,
   input  logic [11:0]           pal_data_in,
   input  logic                  transparent_en_in,
   output logic [ADDR_W-1:0]     rom_addr_out,
   input  logic [COLOR_BITS-1:0] rom_data_in,
   output logic [11:0]           pixel_out,
   output logic                  pixel_valid_out
);

   localparam int PAL_N = 2**COLOR_BITS;
   localparam logic [12:0] WIN_W = 13'(IMG_W << SCALE_LOG2);
   localparam logic [11:0] WIN_H = 12'(IMG_H << SCALE_LOG2);

   function automatic logic [11:0] pal_default(input int idx);
      logic [11:0] rgb;
      case (idx)
         1:       rgb = 12'hD00;
         2:       rgb = 12'hF63;
         3:       rgb = 12'hFB3;
         4:       rgb = 12'h273;
         5:       rgb = 12'h17D;
         6:       rgb = 12'h969;
         7:       rgb = 12'h267;
         8:       rgb = 12'hFFF;
         default: rgb = 12'h000;
      endcase
      return rgb;
   endfunction

   logic [11:0] r_act_x, r_pend_x;
   logic [10:0] r_act_y, r_pend_y;
   logic [11:0] r_relx;
   logic [10:0] r_rely;
   logic        r_c1_valid, r_c2_valid, r_c3_valid;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [11:0] r_pixel;
   logic        r_pixel_valid;
   logic [11:0] r_palette [PAL_N];

   logic        w_in_x, w_in_y;
   logic [ADDR_W-1:0] w_addr;
   logic [11:0] w_pal_rgb;
   logic [11:0] w_pixel_next;
   logic        w_valid_next;

   // Widened compares so a window hanging past the raster edge clips instead of wrapping.
   assign w_in_x = ({1'b0, hcount_in} >= {1'b0, r_act_x}) &&
                   ({1'b0, hcount_in} <  ({1'b0, r_act_x} + WIN_W));
   assign w_in_y = ({1'b0, vcount_in} >= {1'b0, r_act_y}) &&
                   ({1'b0, vcount_in} <  ({1'b0, r_act_y} + WIN_H));

   assign w_addr = ADDR_W'(r_rely >> SCALE_LOG2) * ADDR_W'(IMG_W) + ADDR_W'(r_relx >> SCALE_LOG2);
   assign w_pal_rgb = r_palette[rom_data_in];

   // Pending/active window position; active only moves at frame start.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_act_x  <= 12'(DEFAULT_X);
         r_act_y  <= 11'(DEFAULT_Y);
         r_pend_x <= 12'(DEFAULT_X);
         r_pend_y <= 11'(DEFAULT_Y);
      end else begin
         if (pos_we_in) begin
            r_pend_x <= pos_x_in;
            r_pend_y <= pos_y_in;
         end
         if (frame_start_in) begin
            r_act_x <= pos_we_in ? pos_x_in : r_pend_x;
            r_act_y <= pos_we_in ? pos_y_in : r_pend_y;
         end
      end
   end

   // Address pipeline: relative coordinates, then ROM address, then ROM-data alignment.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_relx     <= 12'd0;
         r_rely     <= 11'd0;
         r_c1_valid <= 1'b0;
         r_c2_valid <= 1'b0;
         r_c3_valid <= 1'b0;
         r_rom_addr <= '0;
      end else begin
         r_relx     <= hcount_in - r_act_x;
         r_rely     <= vcount_in - r_act_y;
         r_c1_valid <= w_in_x && w_in_y;
         r_c2_valid <= r_c1_valid;
         r_c3_valid <= r_c2_valid;
         if (r_c1_valid) begin
            r_rom_addr <= w_addr;
         end
      end
   end

   // Palette: reads see the pre-write contents in the cycle of a write.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < PAL_N; i++) begin
            r_palette[i] <= pal_default(i);
         end
      end else if (pal_we_in) begin
         r_palette[pal_addr_in] <= pal_data_in;
      end
   end

   // Final pixel select with optional index-0 transparency.
   always_comb begin
      w_pixel_next = 12'h000;
      w_valid_next = 1'b0;
      if (r_c3_valid && !(transparent_en_in && (rom_data_in == COLOR_BITS'(0)))) begin
         w_pixel_next = w_pal_rgb;
         w_valid_next = 1'b1;
      end else begin
         w_pixel_next = 12'h000;
         w_valid_next = 1'b0;
      end
   end

   // Output register stage.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pixel       <= 12'h000;
         r_pixel_valid <= 1'b0;
      end else begin
         r_pixel       <= w_pixel_next;
         r_pixel_valid <= w_valid_next;
      end
   end

   assign rom_addr_out    = r_rom_addr;
   assign pixel_out       = r_pixel;
   assign pixel_valid_out = r_pixel_valid;

endmodule

// File: tb/tb_scaled_bitmap_display.sv
// Directed self-checking bench for scaled_bitmap_display; the ROM stub returns (addr+1) mod 16.
module tb_scaled_bitmap_display;

   localparam int DX = 100;
   localparam int DY = 50;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic [11:0]   hcount;
   logic [10:0]   vcount;
   logic          frame_start;
   logic [11:0]   pos_x;
   logic [10:0]   pos_y;
   logic          pos_we;
   logic          pal_we;
   logic [3:0]    pal_addr;
   logic [11:0]   pal_data;
   logic          transparent_en;
   logic [AW-1:0] rom_addr;
   logic [3:0]    rom_data;
   logic [11:0]   pixel;
   logic          pixel_valid;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [11:0] a_addr, a_pix;
   logic        a_val, a_val3;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= 4'(rom_addr + 12'd1);

   scaled_bitmap_display #(
      .IMG_W(64), .IMG_H(62), .SCALE_LOG2(3), .COLOR_BITS(4),
      .DEFAULT_X(DX), .DEFAULT_Y(DY)
   ) dut (
      .clk_in(clk), .rst_in(rst),
      .hcount_in(hcount), .vcount_in(vcount), .frame_start_in(frame_start),
      .pos_x_in(pos_x), .pos_y_in(pos_y), .pos_we_in(pos_we),
      .pal_we_in(pal_we), .pal_addr_in(pal_addr), .pal_data_in(pal_data),
      .transparent_en_in(transparent_en),
      .rom_addr_out(rom_addr), .rom_data_in(rom_data),
      .pixel_out(pixel), .pixel_valid_out(pixel_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pixel through the pipe; optional palette write lands in the cycle its lookup happens.
   task automatic run_px(input logic [11:0] h, input logic [10:0] v, input logic te,
                         input logic wr, input logic [3:0] wa, input logic [11:0] wd,
                         output logic [11:0] addr, output logic [11:0] pix,
                         output logic val, output logic val3);
      hcount = h; vcount = v; transparent_en = te;
      tick();
      hcount = 12'd0; vcount = 11'd0;
      tick();
      addr = 12'(rom_addr);
      tick();
      val3 = pixel_valid;
      if (wr) begin
         pal_we = 1'b1; pal_addr = wa; pal_data = wd;
      end
      tick();
      pal_we = 1'b0;
      pix = pixel;
      val = pixel_valid;
   endtask

   task automatic set_pos(input logic [11:0] x, input logic [10:0] y, input logic we, input logic fs);
      pos_x = x; pos_y = y; pos_we = we; frame_start = fs;
      tick();
      pos_we = 1'b0; frame_start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; hcount = 12'd0; vcount = 11'd0; frame_start = 1'b0;
      pos_x = 12'd0; pos_y = 11'd0; pos_we = 1'b0;
      pal_we = 1'b0; pal_addr = 4'd0; pal_data = 12'h000; transparent_en = 1'b0;
      tick(); tick();
      chk("reset_pixel", 16'(pixel), 16'h0000);
      chk("reset_valid", 16'(pixel_valid), 16'h0000);
      chk("reset_addr", 16'(rom_addr), 16'h0000);
      rst = 1'b0;

      // Origin cell, latency 4
      run_px(12'd100, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("origin_addr", 16'(a_addr), 16'd0);
      chk("origin_not_early", 16'(a_val3), 16'd0);
      chk("origin_pix", 16'(a_pix), 16'hD00);
      chk("origin_valid", 16'(a_val), 16'd1);

      // Address map
      run_px(12'd107, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("h107_addr", 16'(a_addr), 16'd0);
      run_px(12'd108, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("h108_addr", 16'(a_addr), 16'd1);
      chk("h108_pix", 16'(a_pix), 16'hF63);
      run_px(12'd100, 11'd58, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("v58_addr", 16'(a_addr), 16'd64);
      chk("v58_pix", 16'(a_pix), 16'hD00);
      run_px(12'd611, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("h611_addr", 16'(a_addr), 16'd63);
      chk("h611_valid", 16'(a_val), 16'd1);
      chk("h611_pix", 16'(a_pix), 16'h000);
      run_px(12'd612, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("h612_valid", 16'(a_val), 16'd0);
      chk("h612_pix", 16'(a_pix), 16'h000);

      // Palette write in the lookup cycle returns old entry, then new one
      run_px(12'd100, 11'd50, 1'b0, 1'b1, 4'd1, 12'h0F0, a_addr, a_pix, a_val, a_val3);
      chk("pal_same_cycle_old", 16'(a_pix), 16'hD00);
      run_px(12'd100, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("pal_new", 16'(a_pix), 16'h0F0);

      // Pending position is not applied until frame start
      set_pos(12'd300, 11'd200, 1'b1, 1'b0);
      run_px(12'd300, 11'd200, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("pend_old_win_addr", 16'(a_addr), 16'd1177);
      chk("pend_old_win_valid", 16'(a_val), 16'd1);
      set_pos(12'd0, 11'd0, 1'b0, 1'b1);
      run_px(12'd300, 11'd200, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("fs_new_addr", 16'(a_addr), 16'd0);
      chk("fs_new_pix", 16'(a_pix), 16'h0F0);
      run_px(12'd100, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("fs_old_gone", 16'(a_val), 16'd0);

      // Coincident write and frame start
      set_pos(12'd500, 11'd300, 1'b1, 1'b1);
      run_px(12'd500, 11'd300, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("coinc_addr", 16'(a_addr), 16'd0);
      chk("coinc_valid", 16'(a_val), 16'd1);
      run_px(12'd300, 11'd200, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("coinc_prev_out", 16'(a_val), 16'd0);

      // Transparency on index 0 (cell 15 -> stub index 0)
      run_px(12'd620, 11'd300, 1'b1, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("transp_addr", 16'(a_addr), 16'd15);
      chk("transp_valid", 16'(a_val), 16'd0);
      chk("transp_pix", 16'(a_pix), 16'h000);
      run_px(12'd620, 11'd300, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("opaque0_valid", 16'(a_val), 16'd1);
      chk("opaque0_pix", 16'(a_pix), 16'h000);

      // Clipping at the right raster edge
      set_pos(12'd4000, 11'd50, 1'b1, 1'b1);
      run_px(12'd4095, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("clip_addr", 16'(a_addr), 16'd11);
      chk("clip_valid", 16'(a_val), 16'd1);
      run_px(12'd3, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("clip_no_wrap", 16'(a_val), 16'd0);

      // Reset mid-window
      hcount = 12'd4095; vcount = 11'd50;
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rst_flush_valid", 16'(pixel_valid), 16'd0);
         chk("rst_flush_pix", 16'(pixel), 16'h000);
         tick();
      end
      chk("rst_default_pos_4095_out", 16'(pixel_valid), 16'd0);
      run_px(12'd100, 11'd50, 1'b0, 1'b0, 4'd0, 12'h000, a_addr, a_pix, a_val, a_val3);
      chk("rst_default_addr", 16'(a_addr), 16'd0);
      chk("rst_default_valid", 16'(a_val), 16'd1);
      chk("rst_palette_pix", 16'(a_pix), 16'hD00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
